cache_arbiter: RTL
==================

CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 Parameter: ADDR_WIDTH, 32, byte address width of all ports.
REQ-002 Parameter: LINE_WIDTH, 256, cache line width of all data ports.
REQ-003 Clocking: the block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 Port: clk  in  1  sole clock, rising edge.
REQ-005 Port: rst_n  in  1  asynchronous active-low reset.
REQ-006 Port: i_pmem_read  in  1  I-cache line-fill request.
REQ-007 Port: i_pmem_address  in  ADDR_WIDTH  I-cache line address.
REQ-008 Port: i_pmem_resp  out  1  I-cache completion pulse.
REQ-009 Port: i_pmem_rdata  out  LINE_WIDTH  I-cache fill data.
REQ-010 Port: d_pmem_read / d_pmem_write  in  1 each  D-cache fill / writeback request.
REQ-011 Port: d_pmem_address  in  ADDR_WIDTH  D-cache line address.
REQ-012 Port: d_pmem_wdata  in  LINE_WIDTH  D-cache writeback data.
REQ-013 Port: d_pmem_resp  out  1  D-cache completion pulse.
REQ-014 Port: d_pmem_rdata  out  LINE_WIDTH  D-cache fill data.
REQ-015 Port: pmem_read / pmem_write  out  1 each  shared memory request.
REQ-016 Port: pmem_address  out  ADDR_WIDTH  shared memory address.
REQ-017 Port: pmem_wdata  out  LINE_WIDTH  shared memory write data.
REQ-018 Port: pmem_resp  in  1  shared memory completion.
REQ-019 Port: pmem_rdata  in  LINE_WIDTH  shared memory read data.

Function
REQ-020 FSM states SHALL be IDLE, SERVE_I, SERVE_D and RESP.
REQ-021 IDLE, single requester pending: the block SHALL grant that requester at the next edge.
REQ-022 IDLE, both pending: the block SHALL grant the requester not granted most recently; the last-grant flag resets to I, so D wins the first tie.
REQ-023 On grant, the block SHALL latch address, wdata, operation and owner; pmem_* SHALL drive only latched values, from the cycle after grant.
REQ-024 D-cache read and write both high: the block SHALL treat it as a write.
REQ-025 SERVE_x: pmem_read/pmem_write SHALL stay asserted until the cycle pmem_resp=1; on that edge the block SHALL capture pmem_rdata, drop the request and enter RESP.
REQ-026 RESP: owner's *_pmem_resp SHALL be high for exactly one cycle with captured rdata; then IDLE. The other requester's resp SHALL stay low.
REQ-027 Minimum latency request-to-resp: grant cycle + 1 memory cycle + RESP = 3 cycles when pmem_resp returns in the first serve cycle.
REQ-028 A requester dropping its request mid-service: the block SHALL complete the pmem transaction and still pulse resp.
REQ-029 New requests arriving during SERVE/RESP SHALL wait; no re-arbitration before IDLE.
REQ-030 pmem_resp in IDLE or RESP SHALL be ignored.
REQ-031 *_pmem_rdata SHALL hold the last captured line between responses.
REQ-032 pmem_read and pmem_write SHALL never both be high.

Reset
REQ-033 rst_n low SHALL force IDLE, last-grant=I, and all outputs/latched registers 0, asynchronously.
REQ-034 Reset mid-transaction SHALL abandon the in-flight pmem access; no resp SHALL be issued for it.

Structure
REQ-035 Package cache_arbiter_pkg SHALL hold the state enum, the owner enum (OWNER_I, OWNER_D) and LINE_WIDTH/ADDR_WIDTH defaults.
REQ-036 FSM and grant logic SHALL live in sub-module cache_arbiter_control; latches and muxes SHALL stay in the top.

Verification
REQ-037 I read 0x0000_1000 only, pmem_resp after 2 cycles with 0xAA..AA -> pmem_read one cycle after request, i_pmem_resp pulse 1 cycle with 0xAA..AA, d_pmem_resp stays 0.
REQ-038 I read and D write 0x0000_2000 same cycle after reset -> D served first (pmem_write, wdata matches), then I served; each resp pulse exactly once.
REQ-039 Both held continuously for 4 transactions -> grants alternate D,I,D,I.
REQ-040 D read and write both high, address 0x40 -> pmem_write only, pmem_read never high.
REQ-041 rst_n low during SERVE_D before pmem_resp -> outputs 0 immediately, no d_pmem_resp; next I request served normally.
REQ-042 D drops request after grant -> pmem access completes and d_pmem_resp pulses once.

Source files
------------

// File: rtl/cache_arbiter_pkg.sv
// Shared types and default widths for the I/D cache to memory arbiter.
package cache_arbiter_pkg;

    localparam int ADDR_WIDTH_DEF = 32;
    localparam int LINE_WIDTH_DEF = 256;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        RESP    = 2'd3
    } state_e;

    typedef enum logic {
        OWNER_I = 1'b0,
        OWNER_D = 1'b1
    } owner_e;

endpackage

// File: rtl/cache_arbiter_control.sv
// Arbitration FSM: picks a requester in IDLE, waits for memory, then issues one response cycle.
module cache_arbiter_control
    import cache_arbiter_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   i_req_i,
    input  logic   d_req_i,
    input  logic   pmem_resp_i,
    output logic   grant_o,
    output owner_e grant_owner_o,
    output logic   serve_o,
    output logic   capture_o,
    output logic   resp_o
);

    state_e state_q, state_d;
    owner_e last_q, last_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= OWNER_I;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    // On a tie the requester that was not granted last wins.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (d_req_i && (!i_req_i || last_q == OWNER_I)) begin
                    state_d = SERVE_D;
                    last_d  = OWNER_D;
                end else if (i_req_i) begin
                    state_d = SERVE_I;
                    last_d  = OWNER_I;
                end
            end
            SERVE_I, SERVE_D: begin
                if (pmem_resp_i) state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        grant_o       = 1'b0;
        grant_owner_o = OWNER_I;
        serve_o       = 1'b0;
        capture_o     = 1'b0;
        resp_o        = 1'b0;
        case (state_q)
            IDLE: begin
                grant_o       = i_req_i | d_req_i;
                grant_owner_o = (state_d == SERVE_D) ? OWNER_D : OWNER_I;
            end
            SERVE_I, SERVE_D: begin
                serve_o   = 1'b1;
                capture_o = pmem_resp_i;
            end
            RESP:    resp_o = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/cache_arbiter.sv
// Shares one line-wide memory port between an I-cache and a D-cache.
module cache_arbiter
    import cache_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int LINE_WIDTH = LINE_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_pmem_read,
    input  logic [ADDR_WIDTH-1:0] i_pmem_address,
    output logic                  i_pmem_resp,
    output logic [LINE_WIDTH-1:0] i_pmem_rdata,
    input  logic                  d_pmem_read,
    input  logic                  d_pmem_write,
    input  logic [ADDR_WIDTH-1:0] d_pmem_address,
    input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
    output logic                  d_pmem_resp,
    output logic [LINE_WIDTH-1:0] d_pmem_rdata,
    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic                  pmem_resp,
    input  logic [LINE_WIDTH-1:0] pmem_rdata
);

    logic   grant, serve, capture, resp;
    owner_e grant_owner;

    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LINE_WIDTH-1:0] wdata_q, wdata_d;
    logic                  write_q, write_d;
    owner_e                owner_q, owner_d;
    logic [LINE_WIDTH-1:0] i_rdata_q, i_rdata_d;
    logic [LINE_WIDTH-1:0] d_rdata_q, d_rdata_d;

    cache_arbiter_control u_control (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_req_i      (i_pmem_read),
        .d_req_i      (d_pmem_read | d_pmem_write),
        .pmem_resp_i  (pmem_resp),
        .grant_o      (grant),
        .grant_owner_o(grant_owner),
        .serve_o      (serve),
        .capture_o    (capture),
        .resp_o       (resp)
    );

    // A D-cache request with both read and write set is taken as a write.
    always_comb begin
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        write_d   = write_q;
        owner_d   = owner_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        if (grant) begin
            owner_d = grant_owner;
            if (grant_owner == OWNER_D) begin
                addr_d  = d_pmem_address;
                wdata_d = d_pmem_wdata;
                write_d = d_pmem_write;
            end else begin
                addr_d  = i_pmem_address;
                wdata_d = '0;
                write_d = 1'b0;
            end
        end
        if (capture) begin
            if (owner_q == OWNER_D) d_rdata_d = pmem_rdata;
            else                    i_rdata_d = pmem_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            write_q   <= 1'b0;
            owner_q   <= OWNER_I;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            write_q   <= write_d;
            owner_q   <= owner_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    assign pmem_read    = serve & ~write_q;
    assign pmem_write   = serve & write_q;
    assign pmem_address = addr_q;
    assign pmem_wdata   = wdata_q;
    assign i_pmem_resp  = resp & (owner_q == OWNER_I);
    assign d_pmem_resp  = resp & (owner_q == OWNER_D);
    assign i_pmem_rdata = i_rdata_q;
    assign d_pmem_rdata = d_rdata_q;

endmodule
